id_stage: RTL and testbench

Instruction-decode stage of the 5-stage MIPS-subset pipeline. It sits directly downstream of the fetch stage and consumes that stage's instruction and PC+4.
- Contains the IF/ID register, a 32x32 register file, the main decoder, branch resolution, the hazard unit and the ID/EX register.
- Feeds pc_branch, pc_source and pc_write back to fetch.
- Feeds registered operands and controls forward to EX.

---
 rtl/id_pkg.sv | 60 ++++++
 rtl/id_stage_regfile.sv | 45 ++++
 rtl/id_stage.sv | 148 ++++++++++++++
 tb/tb_id_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - opcode, ALU-op and control-bundle definitions for the decode stage
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    function automatic ctrl_t decode_op(input logic [5:0] op);
        ctrl_t c;
        c = CTRL_NONE;
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.alu_op    = ALU_OP_FUNCT;
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_op     = ALU_OP_ADD;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_OP_ADD;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_OP_ADD;
            end
            OP_BEQ:  c.alu_op = ALU_OP_SUB;
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// rtl/id_stage_regfile.sv - 32-entry register file, 2 read / 1 write, write-through, r0 hardwired to 0
module regfile
    import id_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [NREG_W-1:0] i_wa,
    input  logic [WIDTH-1:0]  i_wd,
    input  logic [NREG_W-1:0] i_ra1,
    input  logic [NREG_W-1:0] i_ra2,
    output logic [WIDTH-1:0]  o_rd1,
    output logic [WIDTH-1:0]  o_rd2
);

    localparam int NREGS = 1 << NREG_W;

    logic [WIDTH-1:0] r_regs [0:NREGS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Write-through lets decode see a value being written back this same cycle.
    always_comb begin
        o_rd1 = '0;
        o_rd2 = '0;
        if (i_ra1 != '0) begin
            o_rd1 = (i_we && (i_wa == i_ra1)) ? i_wd : r_regs[i_ra1];
        end
        if (i_ra2 != '0) begin
            o_rd2 = (i_we && (i_wa == i_ra2)) ? i_wd : r_regs[i_ra2];
        end
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: IF/ID register, regfile, decoder, hazard unit, branch resolution, ID/EX register
module id_stage
    import id_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  if_pc_next,
    input  logic [31:0]       if_instruction,
    output logic              pc_write,
    output logic              pc_source,
    output logic [WIDTH-1:0]  pc_branch,
    input  logic              wb_reg_write,
    input  logic [NREG_W-1:0] wb_rd,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              mem_mem_read,
    input  logic [NREG_W-1:0] mem_dst,
    output logic [WIDTH-1:0]  idex_pc_next,
    output logic [WIDTH-1:0]  idex_rs_data,
    output logic [WIDTH-1:0]  idex_rt_data,
    output logic [WIDTH-1:0]  idex_imm,
    output logic [NREG_W-1:0] idex_rs,
    output logic [NREG_W-1:0] idex_rt,
    output logic [NREG_W-1:0] idex_rd,
    output logic [5:0]        idex_funct,
    output logic              idex_reg_write,
    output logic              idex_mem_read,
    output logic              idex_mem_write,
    output logic              idex_alu_src,
    output logic              idex_reg_dst,
    output logic              idex_mem_to_reg,
    output logic [1:0]        idex_alu_op
);

    // Idle IF/ID holds PC 0 + 4 so the branch target out of reset is 4.
    localparam logic [WIDTH-1:0] RESET_PC_NEXT = WIDTH'(4);

    logic [31:0]       r_ifid_instr;
    logic [WIDTH-1:0]  r_ifid_pc_next;

    logic [5:0]        w_opcode;
    logic [NREG_W-1:0] w_rs;
    logic [NREG_W-1:0] w_rt;
    logic [NREG_W-1:0] w_rd;
    logic [WIDTH-1:0]  w_imm;
    logic [WIDTH-1:0]  w_rs_data;
    logic [WIDTH-1:0]  w_rt_data;
    ctrl_t             w_ctrl;
    ctrl_t             w_ctrl_issue;
    logic              w_is_beq;
    logic [NREG_W-1:0] w_ex_dst;
    logic              w_load_use;
    logic              w_branch_stall;
    logic              w_stall;
    logic              w_unused_shamt;

    assign w_opcode       = r_ifid_instr[31:26];
    assign w_rs           = r_ifid_instr[21 +: NREG_W];
    assign w_rt           = r_ifid_instr[16 +: NREG_W];
    assign w_rd           = r_ifid_instr[11 +: NREG_W];
    assign w_imm          = {{(WIDTH-16){r_ifid_instr[15]}}, r_ifid_instr[15:0]};
    assign w_unused_shamt = ^r_ifid_instr[10:6];

    regfile #(.WIDTH(WIDTH), .NREG_W(NREG_W)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .i_we  (wb_reg_write),
        .i_wa  (wb_rd),
        .i_wd  (wb_data),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_rs_data),
        .o_rd2 (w_rt_data)
    );

    assign w_ctrl   = decode_op(w_opcode);
    assign w_is_beq = (w_opcode == OP_BEQ);

    assign w_ex_dst   = idex_reg_dst ? idex_rd : idex_rt;
    assign w_load_use = idex_mem_read && (idex_rt != '0)
                        && ((idex_rt == w_rs) || (idex_rt == w_rt));
    // beq compares in ID, so it must also wait for results still in EX or loads in MEM.
    assign w_branch_stall = w_is_beq && (
        (idex_reg_write && (w_ex_dst != '0) && ((w_ex_dst == w_rs) || (w_ex_dst == w_rt))) ||
        (mem_mem_read   && (mem_dst  != '0) && ((mem_dst  == w_rs) || (mem_dst  == w_rt))));
    assign w_stall = w_load_use || w_branch_stall;

    assign pc_write  = !w_stall;
    assign pc_branch = r_ifid_pc_next + (w_imm << 2);
    assign pc_source = w_is_beq && (w_rs_data == w_rt_data) && !w_stall;

    assign w_ctrl_issue = (w_stall || (r_ifid_instr == NOP_INSTR)) ? CTRL_NONE : w_ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ifid_instr   <= NOP_INSTR;
            r_ifid_pc_next <= RESET_PC_NEXT;
        end else if (w_stall) begin
            r_ifid_instr   <= r_ifid_instr;
            r_ifid_pc_next <= r_ifid_pc_next;
        end else if (pc_source) begin
            r_ifid_instr   <= NOP_INSTR;
            r_ifid_pc_next <= '0;
        end else begin
            r_ifid_instr   <= if_instruction;
            r_ifid_pc_next <= if_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_pc_next    <= '0;
            idex_rs_data    <= '0;
            idex_rt_data    <= '0;
            idex_imm        <= '0;
            idex_rs         <= '0;
            idex_rt         <= '0;
            idex_rd         <= '0;
            idex_funct      <= '0;
            idex_reg_write  <= 1'b0;
            idex_mem_read   <= 1'b0;
            idex_mem_write  <= 1'b0;
            idex_alu_src    <= 1'b0;
            idex_reg_dst    <= 1'b0;
            idex_mem_to_reg <= 1'b0;
            idex_alu_op     <= 2'b00;
        end else begin
            idex_pc_next    <= r_ifid_pc_next;
            idex_rs_data    <= w_rs_data;
            idex_rt_data    <= w_rt_data;
            idex_imm        <= w_imm;
            idex_rs         <= w_rs;
            idex_rt         <= w_rt;
            idex_rd         <= w_rd;
            idex_funct      <= r_ifid_instr[5:0];
            idex_reg_write  <= w_ctrl_issue.reg_write;
            idex_mem_read   <= w_ctrl_issue.mem_read;
            idex_mem_write  <= w_ctrl_issue.mem_write;
            idex_alu_src    <= w_ctrl_issue.alu_src;
            idex_reg_dst    <= w_ctrl_issue.reg_dst;
            idex_mem_to_reg <= w_ctrl_issue.mem_to_reg;
            idex_alu_op     <= w_ctrl_issue.alu_op;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

    logic        clk;
    logic        reset;
    logic [31:0] if_pc_next;
    logic [31:0] if_instruction;
    logic        pc_write;
    logic        pc_source;
    logic [31:0] pc_branch;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_mem_read;
    logic [4:0]  mem_dst;
    logic [31:0] idex_pc_next;
    logic [31:0] idex_rs_data;
    logic [31:0] idex_rt_data;
    logic [31:0] idex_imm;
    logic [4:0]  idex_rs;
    logic [4:0]  idex_rt;
    logic [4:0]  idex_rd;
    logic [5:0]  idex_funct;
    logic        idex_reg_write;
    logic        idex_mem_read;
    logic        idex_mem_write;
    logic        idex_alu_src;
    logic        idex_reg_dst;
    logic        idex_mem_to_reg;
    logic [1:0]  idex_alu_op;

    int n_checks;
    int n_errors;

    id_stage #(.WIDTH(32), .NREG_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .if_pc_next      (if_pc_next),
        .if_instruction  (if_instruction),
        .pc_write        (pc_write),
        .pc_source       (pc_source),
        .pc_branch       (pc_branch),
        .wb_reg_write    (wb_reg_write),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .mem_mem_read    (mem_mem_read),
        .mem_dst         (mem_dst),
        .idex_pc_next    (idex_pc_next),
        .idex_rs_data    (idex_rs_data),
        .idex_rt_data    (idex_rt_data),
        .idex_imm        (idex_imm),
        .idex_rs         (idex_rs),
        .idex_rt         (idex_rt),
        .idex_rd         (idex_rd),
        .idex_funct      (idex_funct),
        .idex_reg_write  (idex_reg_write),
        .idex_mem_read   (idex_mem_read),
        .idex_mem_write  (idex_mem_write),
        .idex_alu_src    (idex_alu_src),
        .idex_reg_dst    (idex_reg_dst),
        .idex_mem_to_reg (idex_mem_to_reg),
        .idex_alu_op     (idex_alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] instr, input logic [31:0] pcn);
        if_instruction = instr;
        if_pc_next     = pcn;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        wb_reg_write = en;
        wb_rd        = rd;
        wb_data      = data;
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    localparam logic [31:0] LW_R2  = 32'h8C22_0008;
    localparam logic [31:0] ADD_R3 = 32'h0044_1820;
    localparam logic [31:0] SW_R2  = 32'hAC22_0004;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        fetch(32'h0, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        mem_mem_read = 1'b0;
        mem_dst      = 5'd0;
        tick();
        tick();
        chk("rst_idex_reg_write", 32'(idex_reg_write), 32'd0);
        chk("rst_idex_pc_next", idex_pc_next, 32'h0);
        chk("rst_idex_alu_op", 32'(idex_alu_op), 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        chk("rst_pc_source", 32'(pc_source), 32'd0);
        chk("rst_pc_branch", pc_branch, 32'h4);
        reset = 1'b0;

        // write-through on r5, then r0 writes ignored
        fetch(enc_r(5'd5, 5'd0, 5'd6, 6'h20), 32'h100);
        tick();
        fetch(32'h0, 32'h104);
        wb(1'b1, 5'd5, 32'h1234);
        tick();
        chk("wt_rs_data", idex_rs_data, 32'h1234);
        chk("wt_idex_rs", 32'(idex_rs), 32'd5);
        chk("wt_idex_rd", 32'(idex_rd), 32'd6);
        chk("wt_reg_write", 32'(idex_reg_write), 32'd1);
        chk("wt_reg_dst", 32'(idex_reg_dst), 32'd1);
        chk("wt_alu_op", 32'(idex_alu_op), 32'd2);
        chk("wt_funct", 32'(idex_funct), 32'h20);
        fetch(enc_r(5'd0, 5'd5, 5'd7, 6'h20), 32'h108);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        chk("nop_bubble_reg_write", 32'(idex_reg_write), 32'd0);
        chk("nop_bubble_reg_dst", 32'(idex_reg_dst), 32'd0);
        fetch(32'h0, 32'h10C);
        wb(1'b1, 5'd0, 32'hDEAD);
        tick();
        chk("r0_wt_rs_data", idex_rs_data, 32'h0);
        chk("r5_stored_rt_data", idex_rt_data, 32'h1234);
        fetch(enc_r(5'd0, 5'd0, 5'd8, 6'h20), 32'h110);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        fetch(32'h0, 32'h114);
        tick();
        chk("r0_stored_rs_data", idex_rs_data, 32'h0);
        chk("r0_read_idex_rd", 32'(idex_rd), 32'd8);

        // lw flow, then load-use stall with add r3,r2,r4
        fetch(LW_R2, 32'h200);
        tick();
        fetch(ADD_R3, 32'h204);
        tick();
        chk("lw_mem_read", 32'(idex_mem_read), 32'd1);
        chk("lw_imm", idex_imm, 32'd8);
        chk("lw_rt", 32'(idex_rt), 32'd2);
        chk("lw_alu_op", 32'(idex_alu_op), 32'd0);
        chk("lw_alu_src", 32'(idex_alu_src), 32'd1);
        chk("lw_mem_to_reg", 32'(idex_mem_to_reg), 32'd1);
        chk("lw_reg_dst", 32'(idex_reg_dst), 32'd0);
        chk("lw_pc_next", idex_pc_next, 32'h200);
        chk("lu_pc_write", 32'(pc_write), 32'd0);
        fetch(SW_R2, 32'h208);
        tick();
        chk("lu_bubble_reg_write", 32'(idex_reg_write), 32'd0);
        chk("lu_bubble_mem_read", 32'(idex_mem_read), 32'd0);
        chk("lu_release_pc_write", 32'(pc_write), 32'd1);
        tick();
        chk("add_rd", 32'(idex_rd), 32'd3);
        chk("add_rs", 32'(idex_rs), 32'd2);
        chk("add_rt", 32'(idex_rt), 32'd4);
        chk("add_reg_write", 32'(idex_reg_write), 32'd1);
        chk("add_pc_next", idex_pc_next, 32'h204);
        fetch(32'h0, 32'h20C);
        tick();
        chk("sw_mem_write", 32'(idex_mem_write), 32'd1);
        chk("sw_reg_write", 32'(idex_reg_write), 32'd0);
        chk("sw_imm", idex_imm, 32'd4);

        // taken beq r1,r2,3 with r1 = r2 = 7
        wb(1'b1, 5'd1, 32'd7);
        tick();
        wb(1'b1, 5'd2, 32'd7);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        fetch(enc_i(6'h04, 5'd1, 5'd2, 16'd3), 32'h10);
        tick();
        chk("beq_pc_source", 32'(pc_source), 32'd1);
        chk("beq_pc_branch", pc_branch, 32'h1C);
        chk("beq_pc_write", 32'(pc_write), 32'd1);
        fetch(enc_i(6'h08, 5'd0, 5'd9, 16'd1), 32'h14);
        tick();
        chk("beq_idex_alu_op", 32'(idex_alu_op), 32'd1);
        chk("beq_idex_reg_write", 32'(idex_reg_write), 32'd0);
        chk("flush_pc_source", 32'(pc_source), 32'd0);
        chk("flush_pc_branch", pc_branch, 32'h0);
        fetch(32'h0, 32'h18);
        tick();
        chk("flushed_addi_reg_write", 32'(idex_reg_write), 32'd0);

        // addi r3 then beq r3,r2,2: one branch stall, resolve on write-back value
        fetch(enc_i(6'h08, 5'd0, 5'd3, 16'd7), 32'h20);
        tick();
        fetch(enc_i(6'h04, 5'd3, 5'd2, 16'd2), 32'h24);
        tick();
        chk("bs_pc_write", 32'(pc_write), 32'd0);
        chk("bs_pc_source", 32'(pc_source), 32'd0);
        chk("addi_imm", idex_imm, 32'd7);
        chk("addi_alu_src", 32'(idex_alu_src), 32'd1);
        tick();
        chk("bs_release_pc_write", 32'(pc_write), 32'd1);
        chk("bs_stale_pc_source", 32'(pc_source), 32'd0);
        wb(1'b1, 5'd3, 32'd7);
        #1;
        chk("bs_wt_pc_source", 32'(pc_source), 32'd1);
        chk("bs_wt_pc_branch", pc_branch, 32'h2C);
        fetch(32'h0, 32'h28);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("beq2_alu_op", 32'(idex_alu_op), 32'd1);
        chk("beq2_rs_data", idex_rs_data, 32'd7);

        // reset during a load-use stall
        fetch(LW_R2, 32'h30);
        tick();
        fetch(ADD_R3, 32'h34);
        tick();
        chk("rs_stall_pc_write", 32'(pc_write), 32'd0);
        reset = 1'b1;
        fetch(32'h0, 32'h0);
        tick();
        chk("rs_idex_reg_write", 32'(idex_reg_write), 32'd0);
        chk("rs_idex_mem_read", 32'(idex_mem_read), 32'd0);
        chk("rs_idex_pc_next", idex_pc_next, 32'h0);
        chk("rs_idex_imm", idex_imm, 32'h0);
        chk("rs_idex_rt", 32'(idex_rt), 32'd0);
        chk("rs_idex_rs_data", idex_rs_data, 32'h0);
        chk("rs_pc_write", 32'(pc_write), 32'd1);
        chk("rs_pc_source", 32'(pc_source), 32'd0);
        chk("rs_pc_branch", pc_branch, 32'h4);
        reset = 1'b0;
        fetch(enc_r(5'd1, 5'd2, 5'd5, 6'h20), 32'h4);
        tick();
        fetch(32'h0, 32'h8);
        tick();
        chk("rs_r1_cleared", idex_rs_data, 32'h0);
        chk("rs_r2_cleared", idex_rt_data, 32'h0);
        chk("rs_add_reg_write", 32'(idex_reg_write), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
